qpsk_prbs_checker: RTL

Receive-side counterpart of the PRBS/QPSK transmitter: slices the I and Q samples coming out of the channel model into hard bits and checks each lane against a self-synchronising PRBS9 reference. It sits after the channel (or, later, after the equaliser) in the TX→channel→RX chain. Per lane, it reports lock status, counts compared bits and bit errors, and emits an error pulse. The result is a direct BER measurement for a given `sigma_scale`.

---
 rtl/rx_pkg.sv | 24 ++
 rtl/qpsk_prbs_checker_if.sv | 32 +++
 rtl/prbs9_lane_checker.sv | 172 +++++++++++++++++
 rtl/qpsk_prbs_checker.sv | 59 +++++
 4 files changed

// File: rtl/rx_pkg.sv
// Shared definitions for the PRBS9 receive checker: polynomial taps, lane
// FSM states and default lock/loss thresholds.
package rx_pkg;

    localparam int PRBS_TAP_A = 8;
    localparam int PRBS_TAP_B = 4;
    localparam int HIST_LEN   = 9;

    localparam int DEF_LOCK_LEN = 32;
    localparam int DEF_WIN_LEN  = 128;
    localparam int DEF_LOSS_THR = 16;

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } lane_state_t;

    // x^9 + x^5 + 1 with hist[0] as the newest bit.
    function automatic logic prbs9_predict(input logic [HIST_LEN-1:0] hist);
        return hist[PRBS_TAP_A] ^ hist[PRBS_TAP_B];
    endfunction

endpackage

// File: rtl/qpsk_prbs_checker_if.sv
// Sample/status bundle between the channel side and the I/Q PRBS checker.
interface qpsk_prbs_checker_if #(
    parameter int DWIDTH    = 9,
    parameter int CNT_WIDTH = 32
);

    logic                        en;
    logic                        clr;
    logic signed [DWIDTH-1:0]    rx_I;
    logic signed [DWIDTH-1:0]    rx_Q;
    logic                        lock_I;
    logic                        lock_Q;
    logic                        err_I;
    logic                        err_Q;
    logic        [CNT_WIDTH-1:0] bit_cnt_I;
    logic        [CNT_WIDTH-1:0] bit_cnt_Q;
    logic        [CNT_WIDTH-1:0] err_cnt_I;
    logic        [CNT_WIDTH-1:0] err_cnt_Q;

    modport master (
        output en, clr, rx_I, rx_Q,
        input  lock_I, lock_Q, err_I, err_Q,
        input  bit_cnt_I, bit_cnt_Q, err_cnt_I, err_cnt_Q
    );

    modport slave (
        input  en, clr, rx_I, rx_Q,
        output lock_I, lock_Q, err_I, err_Q,
        output bit_cnt_I, bit_cnt_Q, err_cnt_I, err_cnt_Q
    );

endinterface

// File: rtl/prbs9_lane_checker.sv
// One receive lane: hard slicer, self-synchronising PRBS9 reference with
// search/verify/locked FSM, windowed loss-of-lock and saturating counters.
module prbs9_lane_checker
    import rx_pkg::*;
#(
    parameter int DWIDTH    = 9,
    parameter int CNT_WIDTH = 32,
    parameter int LOCK_LEN  = DEF_LOCK_LEN,
    parameter int WIN_LEN   = DEF_WIN_LEN,
    parameter int LOSS_THR  = DEF_LOSS_THR
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_en,
    input  logic                     i_clr,
    input  logic signed [DWIDTH-1:0] i_rx,
    output logic                     o_lock,
    output logic                     o_err,
    output logic [CNT_WIDTH-1:0]     o_bit_cnt,
    output logic [CNT_WIDTH-1:0]     o_err_cnt
);

    localparam int FW = $clog2(HIST_LEN);
    localparam int MW = (LOCK_LEN > 1) ? $clog2(LOCK_LEN) : 1;
    localparam int WW = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
    localparam int EW = $clog2(WIN_LEN + 1);

    localparam logic [FW-1:0] FILL_LAST  = FW'(HIST_LEN - 1);
    localparam logic [MW-1:0] MATCH_LAST = MW'(LOCK_LEN - 1);
    localparam logic [WW-1:0] WIN_LAST   = WW'(WIN_LEN - 1);
    localparam logic [EW-1:0] LOSS_LIM   = EW'(LOSS_THR);

    lane_state_t            r_state;
    lane_state_t            w_state_next;
    logic [HIST_LEN-1:0]    r_hist;
    logic [HIST_LEN-1:0]    w_hist_next;
    logic [FW-1:0]          r_fill;
    logic [FW-1:0]          w_fill_next;
    logic [MW-1:0]          r_match;
    logic [MW-1:0]          w_match_next;
    logic [WW-1:0]          r_win;
    logic [WW-1:0]          w_win_next;
    logic [EW-1:0]          r_win_err;
    logic [EW-1:0]          w_win_err_next;
    logic [EW-1:0]          w_win_err_sum;
    logic                   r_lock;
    logic                   r_err;
    logic                   w_err_next;
    logic [CNT_WIDTH-1:0]   r_bit_cnt;
    logic [CNT_WIDTH-1:0]   r_err_cnt;
    logic                   w_bit_inc;
    logic                   w_err_inc;
    logic                   w_bit;
    logic                   w_pred;
    logic                   w_miss;
    logic                   w_unused_lsbs;

    // Slicer: the sign bit alone decides; magnitude is irrelevant.
    assign w_bit         = i_rx[DWIDTH-1];
    assign w_unused_lsbs = ^i_rx[DWIDTH-2:0];
    assign w_pred        = prbs9_predict(r_hist);
    assign w_miss        = w_bit ^ w_pred;
    assign w_win_err_sum = r_win_err + EW'(w_miss);

    always_comb begin
        w_state_next   = r_state;
        w_hist_next    = r_hist;
        w_fill_next    = r_fill;
        w_match_next   = r_match;
        w_win_next     = r_win;
        w_win_err_next = r_win_err;
        w_err_next     = 1'b0;
        w_bit_inc      = 1'b0;
        w_err_inc      = 1'b0;

        if (i_en) begin
            unique case (r_state)
                ST_SEARCH: begin
                    w_hist_next = {r_hist[HIST_LEN-2:0], w_bit};
                    if (r_fill == FILL_LAST) begin
                        w_state_next = ST_VERIFY;
                        w_match_next = '0;
                    end else begin
                        w_fill_next = r_fill + 1'b1;
                    end
                end

                ST_VERIFY: begin
                    w_hist_next = {r_hist[HIST_LEN-2:0], w_bit};
                    // An all-zero history would predict zeros forever, so it never qualifies.
                    if (w_miss || (r_hist == '0)) begin
                        w_state_next = ST_SEARCH;
                        w_fill_next  = '0;
                    end else if (r_match == MATCH_LAST) begin
                        w_state_next   = ST_LOCKED;
                        w_win_next     = '0;
                        w_win_err_next = '0;
                    end else begin
                        w_match_next = r_match + 1'b1;
                    end
                end

                ST_LOCKED: begin
                    // Free-run on the prediction so channel errors stay single.
                    w_hist_next = {r_hist[HIST_LEN-2:0], w_pred};
                    w_bit_inc   = 1'b1;
                    w_err_inc   = w_miss;
                    w_err_next  = w_miss;
                    if (r_win == WIN_LAST) begin
                        w_win_next     = '0;
                        w_win_err_next = '0;
                        if (w_win_err_sum > LOSS_LIM) begin
                            w_state_next = ST_SEARCH;
                            w_fill_next  = '0;
                        end
                    end else begin
                        w_win_next     = r_win + 1'b1;
                        w_win_err_next = w_win_err_sum;
                    end
                end

                default: begin
                    w_state_next = ST_SEARCH;
                    w_fill_next  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_SEARCH;
            r_hist    <= '0;
            r_fill    <= '0;
            r_match   <= '0;
            r_win     <= '0;
            r_win_err <= '0;
            r_lock    <= 1'b0;
            r_err     <= 1'b0;
            r_bit_cnt <= '0;
            r_err_cnt <= '0;
        end else begin
            r_state   <= w_state_next;
            r_hist    <= w_hist_next;
            r_fill    <= w_fill_next;
            r_match   <= w_match_next;
            r_win     <= w_win_next;
            r_win_err <= w_win_err_next;
            r_lock    <= (w_state_next == ST_LOCKED);
            r_err     <= w_err_next;

            // A clear coinciding with a counted bit leaves exactly that bit's contribution.
            if (i_clr) begin
                r_bit_cnt <= CNT_WIDTH'(w_bit_inc);
            end else if (w_bit_inc && (r_bit_cnt != '1)) begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end

            if (i_clr) begin
                r_err_cnt <= CNT_WIDTH'(w_err_inc);
            end else if (w_err_inc && (r_err_cnt != '1)) begin
                r_err_cnt <= r_err_cnt + 1'b1;
            end
        end
    end

    assign o_lock    = r_lock;
    assign o_err     = r_err;
    assign o_bit_cnt = r_bit_cnt;
    assign o_err_cnt = r_err_cnt;

endmodule

// File: rtl/qpsk_prbs_checker.sv
// I/Q PRBS9 BER checker: two independent lane checkers sharing en/clr.
module qpsk_prbs_checker
    import rx_pkg::*;
#(
    parameter int DWIDTH    = 9,
    parameter int CNT_WIDTH = 32,
    parameter int LOCK_LEN  = DEF_LOCK_LEN,
    parameter int WIN_LEN   = DEF_WIN_LEN,
    parameter int LOSS_THR  = DEF_LOSS_THR
) (
    input  logic                 clk,
    input  logic                 rst,
    qpsk_prbs_checker_if.slave   bus
);

    localparam int N_LANES = 2;

    logic signed [DWIDTH-1:0]    w_rx      [N_LANES];
    logic                        w_lock    [N_LANES];
    logic                        w_err     [N_LANES];
    logic        [CNT_WIDTH-1:0] w_bit_cnt [N_LANES];
    logic        [CNT_WIDTH-1:0] w_err_cnt [N_LANES];

    // Lane 0 is I, lane 1 is Q.
    assign w_rx[0] = bus.rx_I;
    assign w_rx[1] = bus.rx_Q;

    generate
        for (genvar gi = 0; gi < N_LANES; gi++) begin : g_lane
            prbs9_lane_checker #(
                .DWIDTH    (DWIDTH),
                .CNT_WIDTH (CNT_WIDTH),
                .LOCK_LEN  (LOCK_LEN),
                .WIN_LEN   (WIN_LEN),
                .LOSS_THR  (LOSS_THR)
            ) u_lane (
                .clk       (clk),
                .rst       (rst),
                .i_en      (bus.en),
                .i_clr     (bus.clr),
                .i_rx      (w_rx[gi]),
                .o_lock    (w_lock[gi]),
                .o_err     (w_err[gi]),
                .o_bit_cnt (w_bit_cnt[gi]),
                .o_err_cnt (w_err_cnt[gi])
            );
        end
    endgenerate

    assign bus.lock_I    = w_lock[0];
    assign bus.lock_Q    = w_lock[1];
    assign bus.err_I     = w_err[0];
    assign bus.err_Q     = w_err[1];
    assign bus.bit_cnt_I = w_bit_cnt[0];
    assign bus.bit_cnt_Q = w_bit_cnt[1];
    assign bus.err_cnt_I = w_err_cnt[0];
    assign bus.err_cnt_Q = w_err_cnt[1];

endmodule
